spi_master_packet_rx: RTL and testbench

FPGA-side SPI master (Mode 0, CPOL=0/CPHA=0) that reads one 16-byte sensor packet per request from an SPI slave. The packet is 0xAA header, quat w/x/y/z, gyro x/y/z (each MSB first), then a flags byte. The block drives cs_n and sck, samples MISO and deserialises 128 bits MSB first. It checks the header and presents the decoded fields with a one-cycle valid strobe. It serves as the on-board loopback/self-test reader and as the host-side model of the MCU link.

---
 rtl/spi_master_packet_rx_if.sv | 42 ++++
 rtl/spi_master_packet_rx.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_packet_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_packet_rx_if.sv
// ============================================================================
// Module   : spi_master_packet_rx_if
// Brief    : Request, SPI bus and decoded-packet signals of the packet reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_master_packet_rx_if;
    logic               start;
    logic               busy;
    logic               cs_n;
    logic               sck;
    logic               sdo;
    logic               sdi;
    logic               packet_valid;
    logic               header_err;
    logic signed [15:0] quat_w;
    logic signed [15:0] quat_x;
    logic signed [15:0] quat_y;
    logic signed [15:0] quat_z;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
    logic               quat_valid;
    logic               gyro_valid;

    modport master (
        input  start, sdi,
        output busy, cs_n, sck, sdo, packet_valid, header_err,
        output quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
        output quat_valid, gyro_valid
    );

    modport slave (
        output start, sdi,
        input  busy, cs_n, sck, sdo, packet_valid, header_err,
        input  quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z,
        input  quat_valid, gyro_valid
    );
endinterface

`default_nettype wire

// File: rtl/spi_master_packet_rx.sv
// ============================================================================
// Module   : spi_master_packet_rx
// Brief    : Mode-0 SPI master reading one 16-byte sensor packet per request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master_packet_rx #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter logic [7:0]  HEADER   = 8'hAA
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    spi_master_packet_rx_if.master  bus
);

    localparam logic [7:0] c_div_load   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_setup_load = 8'(CS_SETUP - 1);
    localparam logic [7:0] c_hold_load  = 8'(CS_HOLD - 1);
    localparam int         c_num_fields = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic [6:0]     r_bit_cnt;
    logic [6:0]     w_bit_cnt_nxt;
    logic [127:0]   r_shift;
    logic [127:0]   w_shift_nxt;
    logic           r_sck;
    logic           w_sck_nxt;
    logic           r_cs_n;
    logic           w_cs_n_nxt;
    logic           r_sdi_meta;
    logic           r_sdi_s;
    logic           r_packet_valid;
    logic           r_header_err;
    logic           r_quat_valid;
    logic           r_gyro_valid;
    logic           w_frame_end;
    logic           w_hdr_ok;
    logic           w_load;
    logic           w_unused_flags;

    // MISO is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdi_meta <= 1'b0;
            r_sdi_s    <= 1'b0;
        end else begin
            r_sdi_meta <= bus.sdi;
            r_sdi_s    <= r_sdi_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_bit_cnt <= 7'd0;
            r_shift   <= '0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sck     <= w_sck_nxt;
            r_cs_n    <= w_cs_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_sck_nxt     = r_sck;
        w_cs_n_nxt    = r_cs_n;
        case (r_state)
            S_IDLE: begin
                w_cs_n_nxt = 1'b1;
                w_sck_nxt  = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_setup_load;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            S_SETUP: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt   = S_XFER;
                    w_cnt_nxt     = c_div_load;
                    w_bit_cnt_nxt = 7'd0;
                end
            end
            S_XFER: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else if (!r_sck) begin
                    w_sck_nxt = 1'b1;
                    w_cnt_nxt = c_div_load;
                end else begin
                    // Last clk of the high phase: the slave launched this bit a full
                    // half-period ago, so the synchronised copy is settled.
                    w_shift_nxt   = {r_shift[126:0], r_sdi_s};
                    w_bit_cnt_nxt = r_bit_cnt + 7'd1;
                    w_sck_nxt     = 1'b0;
                    if (r_bit_cnt == 7'd127) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = c_hold_load;
                    end else begin
                        w_cnt_nxt   = c_div_load;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_cs_n_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cs_n_nxt  = 1'b1;
                w_sck_nxt   = 1'b0;
            end
        endcase
    end

    // Strobes and field loads are registered on the HOLD->DONE edge so they
    // coincide with the DONE cycle.
    assign w_frame_end = (r_state == S_HOLD) && (r_cnt == 8'd0);
    assign w_hdr_ok    = (r_shift[127:120] == HEADER);
    assign w_load      = w_frame_end && w_hdr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packet_valid <= 1'b0;
            r_header_err   <= 1'b0;
            r_quat_valid   <= 1'b0;
            r_gyro_valid   <= 1'b0;
        end else begin
            r_packet_valid <= w_load;
            r_header_err   <= w_frame_end && !w_hdr_ok;
            if (w_load) begin
                r_quat_valid <= r_shift[0];
                r_gyro_valid <= r_shift[1];
            end
        end
    end

    // Field i sits right after the header: w, x, y, z, gx, gy, gz.
    genvar gi;
    generate
        for (gi = 0; gi < c_num_fields; gi++) begin : g_field
            logic [15:0] r_val;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= 16'd0;
                end else if (w_load) begin
                    r_val <= r_shift[119 - 16*gi -: 16];
                end
            end
        end
    endgenerate

    assign w_unused_flags   = ^r_shift[7:2];

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.cs_n         = r_cs_n;
    assign bus.sck          = r_sck;
    assign bus.sdo          = 1'b0;
    assign bus.packet_valid = r_packet_valid;
    assign bus.header_err   = r_header_err;
    assign bus.quat_w       = g_field[0].r_val;
    assign bus.quat_x       = g_field[1].r_val;
    assign bus.quat_y       = g_field[2].r_val;
    assign bus.quat_z       = g_field[3].r_val;
    assign bus.gyro_x       = g_field[4].r_val;
    assign bus.gyro_y       = g_field[5].r_val;
    assign bus.gyro_z       = g_field[6].r_val;
    assign bus.quat_valid   = r_quat_valid;
    assign bus.gyro_valid   = r_gyro_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_packet_rx.sv
// ============================================================================
// Module   : tb_spi_master_packet_rx
// Brief    : Directed self-checking bench for spi_master_packet_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_packet_rx;

    localparam logic [127:0] c_good = 128'hAA_1234_FEDC_0001_8000_7FFF_0010_FFF0_03;
    localparam logic [127:0] c_bad  = 128'h55_2222_2222_2222_2222_2222_2222_2222_00;
    localparam logic [127:0] c_alt  = 128'hAA_AA55_55AA_AA55_55AA_0FF0_A55A_55AA_02;
    // {w, x, y, z, gx, gy, gz, quat_valid, gyro_valid}
    localparam logic [113:0] c_good_f = {16'h1234, 16'hFEDC, 16'h0001, 16'h8000,
                                         16'h7FFF, 16'h0010, 16'hFFF0, 1'b1, 1'b1};
    localparam logic [113:0] c_alt_f  = {16'hAA55, 16'h55AA, 16'hAA55, 16'h55AA,
                                         16'h0FF0, 16'hA55A, 16'h55AA, 1'b0, 1'b1};
    // start edge k -> strobe in cycle k + 1 + CS_SETUP + 256*CLK_DIV + CS_HOLD
    localparam int c_lat4 = 1 + 4 + 256*4 + 4;
    localparam int c_lat3 = 1 + 4 + 256*3 + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    spi_master_packet_rx_if ifc0 ();
    spi_master_packet_rx_if ifc1 ();

    spi_master_packet_rx u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    spi_master_packet_rx #(.CLK_DIV(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    always #5 clk = ~clk;

    logic [113:0] f0;
    logic [113:0] f1;
    assign f0 = {ifc0.quat_w, ifc0.quat_x, ifc0.quat_y, ifc0.quat_z,
                 ifc0.gyro_x, ifc0.gyro_y, ifc0.gyro_z, ifc0.quat_valid, ifc0.gyro_valid};
    assign f1 = {ifc1.quat_w, ifc1.quat_x, ifc1.quat_y, ifc1.quat_z,
                 ifc1.gyro_x, ifc1.gyro_y, ifc1.gyro_z, ifc1.quat_valid, ifc1.gyro_valid};

    // Mode-0 slaves: MSB presented at cs_n fall, next bit launched on each sck fall.
    logic [127:0] slv0_data = c_good;
    logic [127:0] slv1_data = c_alt;
    logic [6:0]   slv0_idx = 7'd0;
    logic [6:0]   slv1_idx = 7'd0;
    logic         slv0_cs_q = 1'b1;
    logic         slv1_cs_q = 1'b1;

    always @(ifc0.cs_n or negedge ifc0.sck) begin
        if (ifc0.cs_n || slv0_cs_q) slv0_idx = 7'd0;
        else                        slv0_idx = slv0_idx + 7'd1;
        slv0_cs_q = ifc0.cs_n;
        ifc0.sdi  = slv0_data[7'd127 - slv0_idx];
    end

    always @(ifc1.cs_n or negedge ifc1.sck) begin
        if (ifc1.cs_n || slv1_cs_q) slv1_idx = 7'd0;
        else                        slv1_idx = slv1_idx + 7'd1;
        slv1_cs_q = ifc1.cs_n;
        ifc1.sdi  = slv1_data[7'd127 - slv1_idx];
    end

    int pv0 = 0, he0 = 0, both0 = 0, rise0 = 0, frames0 = 0, rise1 = 0;
    always @(negedge clk) begin
        if (ifc0.packet_valid) pv0++;
        if (ifc0.header_err) he0++;
        if (ifc0.packet_valid && ifc0.header_err) both0++;
    end
    always @(posedge ifc0.sck) rise0++;
    always @(posedge ifc1.sck) rise1++;
    always @(negedge ifc0.cs_n) frames0++;

    task automatic pulse_and_wait0(output int lat, output int rises);
        int r_base;
        @(negedge clk);
        ifc0.start = 1'b1;
        r_base = rise0;
        @(negedge clk);
        ifc0.start = 1'b0;
        lat = 1;
        while (!(ifc0.packet_valid || ifc0.header_err) && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        rises = rise0 - r_base;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (ifc0.cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", ifc0.cs_n); end
        n_checks++; if (ifc0.sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", ifc0.sck); end
        n_checks++; if ({ifc0.busy, ifc0.sdo, ifc0.packet_valid, ifc0.header_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {ifc0.busy, ifc0.sdo, ifc0.packet_valid, ifc0.header_err}); end
        n_checks++; if (f0 !== 114'd0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", f0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ifc0.busy !== 1'b0 || ifc0.cs_n !== 1'b1) begin
            n_fail++; $display("FAIL idle_no_start: busy=%b cs_n=%b expected 0/1", ifc0.busy, ifc0.cs_n); end
    endtask

    task automatic test_good_packet();
        int lat, rises;
        slv0_data = c_good;
        pulse_and_wait0(lat, rises);
        n_checks++; if (lat !== c_lat4) begin n_fail++; $display("FAIL good_latency: got %0d expected %0d", lat, c_lat4); end
        n_checks++; if (ifc0.packet_valid !== 1'b1 || ifc0.header_err !== 1'b0) begin
            n_fail++; $display("FAIL good_strobes: pv=%b he=%b expected 1/0", ifc0.packet_valid, ifc0.header_err); end
        n_checks++; if (f0 !== c_good_f) begin n_fail++; $display("FAIL good_fields: got %h expected %h", f0, c_good_f); end
        n_checks++; if ($signed(ifc0.quat_x) != -292) begin n_fail++; $display("FAIL good_quat_x_signed: got %0d expected -292", $signed(ifc0.quat_x)); end
        n_checks++; if (rises !== 128) begin n_fail++; $display("FAIL good_sck_rises: got %0d expected 128", rises); end
        @(negedge clk);
        n_checks++; if (ifc0.packet_valid !== 1'b0 || ifc0.busy !== 1'b0) begin
            n_fail++; $display("FAIL good_pulse_width: pv=%b busy=%b expected 0/0", ifc0.packet_valid, ifc0.busy); end
    endtask

    task automatic test_header_err();
        int lat, rises;
        slv0_data = c_bad;
        pulse_and_wait0(lat, rises);
        n_checks++; if (lat !== c_lat4) begin n_fail++; $display("FAIL bad_latency: got %0d expected %0d", lat, c_lat4); end
        n_checks++; if (ifc0.header_err !== 1'b1 || ifc0.packet_valid !== 1'b0) begin
            n_fail++; $display("FAIL bad_strobes: he=%b pv=%b expected 1/0", ifc0.header_err, ifc0.packet_valid); end
        n_checks++; if (f0 !== c_good_f) begin n_fail++; $display("FAIL bad_fields_held: got %h expected %h", f0, c_good_f); end
        @(negedge clk);
        n_checks++; if (ifc0.header_err !== 1'b0) begin n_fail++; $display("FAIL bad_pulse_width: he=%b expected 0", ifc0.header_err); end
        slv0_data = c_good;
    endtask

    task automatic test_back_to_back();
        int  n = 0, strobes = 0, falls = 0, hi_run = 0, min_gap = 999;
        int  setup_cnt = 0, setup_ok = 0, f_base;
        bit  measuring = 1'b0;
        logic prev_cs = 1'b1;
        f_base = frames0;
        @(negedge clk);
        ifc0.start = 1'b1;
        while (strobes < 3 && n < 6000) begin
            @(negedge clk);
            n++;
            if (ifc0.packet_valid) strobes++;
            if (ifc0.cs_n) hi_run++;
            if (prev_cs && !ifc0.cs_n) begin
                falls++;
                if (falls > 1 && hi_run < min_gap) min_gap = hi_run;
                measuring = 1'b1;
                setup_cnt = 0;
                if (falls == 3) ifc0.start = 1'b0;
            end else if (measuring) begin
                setup_cnt++;
                if (ifc0.sck) begin
                    measuring = 1'b0;
                    // SETUP phase followed by the first low half-period of bit 0
                    if (setup_cnt == 4 + 4) setup_ok++;
                end
            end
            if (!ifc0.cs_n) hi_run = 0;
            prev_cs = ifc0.cs_n;
        end
        ifc0.start = 1'b0;
        n_checks++; if (strobes !== 3) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 3", strobes); end
        n_checks++; if (!(min_gap >= 2 && min_gap != 999)) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected >=2", min_gap); end
        n_checks++; if (setup_ok !== 3) begin n_fail++; $display("FAIL b2b_setup_interval: got %0d good frames expected 3", setup_ok); end
        n_checks++; if (f0 !== c_good_f) begin n_fail++; $display("FAIL b2b_fields: got %h expected %h", f0, c_good_f); end
        repeat (20) @(negedge clk);
        n_checks++; if (frames0 - f_base !== 3) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 3", frames0 - f_base); end
    endtask

    task automatic test_start_during_xfer();
        int pv_base, he_base, f_base, n;
        pv_base = pv0; he_base = he0; f_base = frames0;
        @(negedge clk); ifc0.start = 1'b1;
        @(negedge clk); ifc0.start = 1'b0;
        repeat (400) @(negedge clk);
        ifc0.start = 1'b1;
        @(negedge clk); ifc0.start = 1'b0;
        n = 0;
        while (!ifc0.packet_valid && n < 2000) begin @(negedge clk); n++; end
        n_checks++; if (ifc0.packet_valid !== 1'b1) begin n_fail++; $display("FAIL xfer_start_strobe: pv=%b expected 1", ifc0.packet_valid); end
        repeat (1200) @(negedge clk);
        n_checks++; if (pv0 - pv_base !== 1 || he0 - he_base !== 0) begin
            n_fail++; $display("FAIL xfer_start_count: pv=%0d he=%0d expected 1/0", pv0 - pv_base, he0 - he_base); end
        n_checks++; if (frames0 - f_base !== 1) begin n_fail++; $display("FAIL xfer_start_frames: got %0d expected 1", frames0 - f_base); end
    endtask

    task automatic test_reset_midframe();
        int pv_base, he_base, f_base, r_base, n, lat, rises;
        pv_base = pv0; he_base = he0; f_base = frames0;
        @(negedge clk); ifc0.start = 1'b1;
        r_base = rise0;
        @(negedge clk); ifc0.start = 1'b0;
        n = 0;
        while (rise0 - r_base < 60 && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ifc0.cs_n !== 1'b1 || ifc0.sck !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_pins: cs_n=%b sck=%b expected 1/0", ifc0.cs_n, ifc0.sck); end
        n_checks++; if (f0 !== 114'd0) begin n_fail++; $display("FAIL rst_fields: got %h expected 0", f0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) @(negedge clk);
        n_checks++; if (pv0 - pv_base !== 0 || he0 - he_base !== 0 || frames0 - f_base !== 1) begin
            n_fail++; $display("FAIL rst_no_strobe: pv=%0d he=%0d frames=%0d expected 0/0/1", pv0 - pv_base, he0 - he_base, frames0 - f_base); end
        pulse_and_wait0(lat, rises);
        n_checks++; if (lat !== c_lat4 || ifc0.packet_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_recover: lat=%0d pv=%b expected %0d/1", lat, ifc0.packet_valid, c_lat4); end
        n_checks++; if (f0 !== c_good_f || rises !== 128) begin
            n_fail++; $display("FAIL rst_recover_data: got %h rises=%0d expected %h/128", f0, rises, c_good_f); end
    endtask

    task automatic test_clkdiv3();
        int lat, r_base;
        slv1_data = c_alt;
        @(negedge clk); ifc1.start = 1'b1;
        r_base = rise1;
        @(negedge clk); ifc1.start = 1'b0;
        lat = 1;
        while (!(ifc1.packet_valid || ifc1.header_err) && lat < 3000) begin @(negedge clk); lat++; end
        n_checks++; if (lat !== c_lat3 || ifc1.packet_valid !== 1'b1) begin
            n_fail++; $display("FAIL div3_latency: lat=%0d pv=%b expected %0d/1", lat, ifc1.packet_valid, c_lat3); end
        n_checks++; if (f1 !== c_alt_f) begin n_fail++; $display("FAIL div3_fields: got %h expected %h", f1, c_alt_f); end
        n_checks++; if (rise1 - r_base !== 128) begin n_fail++; $display("FAIL div3_sck_rises: got %0d expected 128", rise1 - r_base); end
    endtask

    initial begin
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        test_reset();
        test_good_packet();
        test_header_err();
        test_back_to_back();
        test_start_during_xfer();
        test_reset_midframe();
        test_clkdiv3();
        n_checks++; if (both0 !== 0) begin n_fail++; $display("FAIL strobes_exclusive: got %0d overlapping cycles expected 0", both0); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
